axi4_lite_reg_slave: RTL
========================

// Module: axi4_lite_reg_slave
// PURPOSE
//  AXI4-Lite slave terminating a master's AXI4-Lite port in a bank of NUM_REGS software-visible
//  control registers. It is the downstream consumer of an AXI4-Lite master interface.
//  Register contents drive o_regs to the datapath. Reads of register k return the stored
//  value, or i_ro[k] when RO_MASK[k]=1.
//  Accepts one write and one read outstanding at a time. Read and write channels are independent.
// PARAMETERS
//  ADDR_WIDTH  32          byte address width of awaddr/araddr
//  DATA_WIDTH  32          data width; must be 32 or 64
//  NUM_REGS    8           register count; power of 2, >=2
//  RO_MASK     '0          bit k=1: reg k read-only (reads i_ro[k], writes ignored, OKAY)
// PORTS
//  i_clk     in   1                      clock, rising edge
//  i_rst_n   in   1                      asynchronous active-low reset
//  i_awvalid in   1                      write address valid
//  o_awready out  1                      write address ready
//  i_awaddr  in   ADDR_WIDTH             write byte address
//  i_awprot  in   3                      ignored
//  i_wvalid  in   1                      write data valid
//  o_wready  out  1                      write data ready
//  i_wdata   in   DATA_WIDTH             write data
//  i_wstrb   in   DATA_WIDTH/8           byte enables
//  o_bvalid  out  1                      write response valid
//  i_bready  in   1                      write response ready
//  o_bresp   out  2                      00 OKAY, 10 SLVERR
//  i_arvalid in   1                      read address valid
//  o_arready out  1                      read address ready
//  i_araddr  in   ADDR_WIDTH             read byte address
//  i_arprot  in   3                      ignored
//  o_rvalid  out  1                      read data valid
//  i_rready  in   1                      read data ready
//  o_rdata   out  DATA_WIDTH             read data
//  o_rresp   out  2                      00 OKAY, 10 SLVERR
//  i_ro      in   NUM_REGS*DATA_WIDTH    read-only sources, reg k at [k*DATA_WIDTH+:DATA_WIDTH]
//  o_regs    out  NUM_REGS*DATA_WIDTH    register contents, same packing
// BEHAVIOUR
//  Reset (i_rst_n=0, async):
//   - all regs=0; o_bvalid=o_rvalid=0; o_bresp=o_rresp=0; o_rdata=0
//   - o_awready=o_wready=o_arready=1 from first cycle after deassert
//   - any in-flight transaction is dropped, with no response
//  Decode:
//   - LSB = log2(DATA_WIDTH/8); idx = addr[LSB+:log2(NUM_REGS)]
//   - addr >= NUM_REGS*DATA_WIDTH/8 -> SLVERR; low LSB address bits ignored
//  Write path, states W_IDLE / W_HAVE_AW / W_HAVE_W / W_RESP:
//   - AW and W latched independently; o_awready=1 iff no AW held and not W_RESP; same rule for o_wready
//   - both captured in the same cycle, or the second one arrives: regs updated on the next edge
//     (byte j written iff wstrb[j]); o_bvalid=1 that same edge
//   - AW and W handshaked together in W_IDLE -> o_bvalid at cycle+1
//   - out-of-range or RO target: no reg change; out-of-range -> SLVERR, RO -> OKAY
//   - W_RESP holds o_bvalid/o_bresp stable until i_bready; then W_IDLE, readies reassert next cycle
//  Read path, states R_IDLE / R_RESP:
//   - o_arready = (state==R_IDLE)
//   - on AR handshake: o_rdata/o_rresp registered, o_rvalid=1 next cycle (latency 1)
//   - out-of-range -> rdata=0, SLVERR
//   - R_RESP holds rdata stable until i_rready, regardless of later reg writes or i_ro changes
//  Collisions and concurrency:
//   - read capture in the same cycle as a write commit to the same reg returns the pre-write value
//   - read and write channels proceed fully in parallel
//  Misc:
//   - valid inputs may drop before handshake (tolerated, not AXI-legal)
//   - o_regs is a direct register output, no extra latency
// TESTING
//  1. Reset, then AW+W same cycle: addr 0x4, data 0xDEADBEEF, strb F
//     -> bvalid at +1, OKAY; o_regs[1]=0xDEADBEEF; AR 0x4 -> rdata 0xDEADBEEF, OKAY
//  2. W first, AW 3 cycles later, strb 0x3, data 0x12345678 to reg1 holding 0xDEADBEEF
//     -> reg1=0xDEAD5678; wready low until bready
//  3. AW addr 0x20 (NUM_REGS=8) -> bresp 10, regs unchanged; AR 0x20 -> rdata 0, rresp 10
//  4. bready/rready held low 5 cycles -> bvalid/rvalid and data stable; awready/wready/arready stay 0
//  5. Same-cycle AR and commit to reg2 (old 0, new 0xA5A5A5A5) -> rdata 0; next read 0xA5A5A5A5
//  6. Assert i_rst_n low while bvalid pending and mid-read -> all valids 0 immediately, regs 0; RO_MASK[3]=1 reg reads i_ro

Source files
------------

// File: rtl/axi4_lite_reg_slave.sv
// AXI4-Lite slave backed by a bank of NUM_REGS control registers.
// The write channel keeps AW and W in separate holding registers and commits
// once both are present. The read channel returns registered data one cycle
// after the address handshake. Registers whose RO_MASK bit is set read from
// i_ro and silently ignore writes.
module axi4_lite_reg_slave #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS = 8,
  parameter logic [NUM_REGS-1:0] RO_MASK = '0
) (
  input  logic                           i_clk,
  input  logic                           i_rst_n,
  input  logic                           i_awvalid,
  output logic                           o_awready,
  input  logic [ADDR_WIDTH-1:0]          i_awaddr,
  input  logic [2:0]                     i_awprot,
  input  logic                           i_wvalid,
  output logic                           o_wready,
  input  logic [DATA_WIDTH-1:0]          i_wdata,
  input  logic [DATA_WIDTH/8-1:0]        i_wstrb,
  output logic                           o_bvalid,
  input  logic                           i_bready,
  output logic [1:0]                     o_bresp,
  input  logic                           i_arvalid,
  output logic                           o_arready,
  input  logic [ADDR_WIDTH-1:0]          i_araddr,
  input  logic [2:0]                     i_arprot,
  output logic                           o_rvalid,
  input  logic                           i_rready,
  output logic [DATA_WIDTH-1:0]          o_rdata,
  output logic [1:0]                     o_rresp,
  input  logic [NUM_REGS*DATA_WIDTH-1:0] i_ro,
  output logic [NUM_REGS*DATA_WIDTH-1:0] o_regs
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int LSB    = $clog2(STRB_W);
  localparam int IDX_W  = $clog2(NUM_REGS);
  localparam int TOP    = LSB + IDX_W;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_HAVE_AW, W_HAVE_W, W_RESP} wstate_e;
  typedef enum logic {R_IDLE, R_RESP} rstate_e;

  wstate_e                     wstate_q, wstate_d;
  rstate_e                     rstate_q, rstate_d;

  logic [IDX_W-1:0]            aw_idx_q, aw_idx_d;
  logic                        aw_err_q, aw_err_d;
  logic [DATA_WIDTH-1:0]       wdata_q, wdata_d;
  logic [STRB_W-1:0]           wstrb_q, wstrb_d;
  logic [1:0]                  bresp_q, bresp_d;
  logic [NUM_REGS*DATA_WIDTH-1:0] regs_q, regs_d;
  logic [DATA_WIDTH-1:0]       rdata_q, rdata_d;
  logic [1:0]                  rresp_q, rresp_d;

  logic                        aw_hs, w_hs, ar_hs, commit;
  logic [IDX_W-1:0]            aw_idx_in, ar_idx;
  logic                        aw_err_in, ar_err;
  logic [IDX_W-1:0]            cmt_idx;
  logic                        cmt_err;
  logic [DATA_WIDTH-1:0]       cmt_wdata;
  logic [STRB_W-1:0]           cmt_strb;
  logic [DATA_WIDTH-1:0]       rd_word;

  // Protection bits and sub-word address bits carry no meaning here.
  logic unused_bits;
  assign unused_bits = ^{i_awprot, i_arprot, i_awaddr[LSB-1:0], i_araddr[LSB-1:0]};

  assign aw_hs     = i_awvalid & o_awready;
  assign w_hs      = i_wvalid & o_wready;
  assign ar_hs     = i_arvalid & o_arready;

  // Anything addressing beyond the bank shows up as a non-zero upper address slice.
  assign aw_idx_in = i_awaddr[LSB +: IDX_W];
  assign aw_err_in = |i_awaddr[ADDR_WIDTH-1:TOP];
  assign ar_idx    = i_araddr[LSB +: IDX_W];
  assign ar_err    = |i_araddr[ADDR_WIDTH-1:TOP];

  // The commit uses whichever half arrives this cycle, otherwise the held copy.
  assign cmt_idx   = aw_hs ? aw_idx_in : aw_idx_q;
  assign cmt_err   = aw_hs ? aw_err_in : aw_err_q;
  assign cmt_wdata = w_hs ? i_wdata : wdata_q;
  assign cmt_strb  = w_hs ? i_wstrb : wstrb_q;

  assign commit = ((wstate_q == W_IDLE) && aw_hs && w_hs) ||
                  ((wstate_q == W_HAVE_AW) && w_hs) ||
                  ((wstate_q == W_HAVE_W) && aw_hs);

  // Write and read channel state registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wstate_q <= W_IDLE;
      rstate_q <= R_IDLE;
    end else begin
      wstate_q <= wstate_d;
      rstate_q <= rstate_d;
    end
  end

  // Write channel next state: wait for both halves, then hold the response.
  always_comb begin
    wstate_d = wstate_q;
    case (wstate_q)
      W_IDLE: begin
        if (aw_hs && w_hs) wstate_d = W_RESP;
        else if (aw_hs)    wstate_d = W_HAVE_AW;
        else if (w_hs)     wstate_d = W_HAVE_W;
      end
      W_HAVE_AW: if (w_hs)     wstate_d = W_RESP;
      W_HAVE_W:  if (aw_hs)    wstate_d = W_RESP;
      W_RESP:    if (i_bready) wstate_d = W_IDLE;
      default:   wstate_d = W_IDLE;
    endcase
  end

  // Write channel outputs: each ready drops once its half is held.
  always_comb begin
    o_awready = (wstate_q == W_IDLE) || (wstate_q == W_HAVE_W);
    o_wready  = (wstate_q == W_IDLE) || (wstate_q == W_HAVE_AW);
    o_bvalid  = (wstate_q == W_RESP);
  end

  // Read channel next state: one response in flight at a time.
  always_comb begin
    rstate_d = rstate_q;
    case (rstate_q)
      R_IDLE:  if (ar_hs)    rstate_d = R_RESP;
      R_RESP:  if (i_rready) rstate_d = R_IDLE;
      default: rstate_d = R_IDLE;
    endcase
  end

  // Read channel outputs.
  always_comb begin
    o_arready = (rstate_q == R_IDLE);
    o_rvalid  = (rstate_q == R_RESP);
  end

  // Holding registers, byte-masked register update and write response code.
  always_comb begin
    int base;
    aw_idx_d = aw_hs ? aw_idx_in : aw_idx_q;
    aw_err_d = aw_hs ? aw_err_in : aw_err_q;
    wdata_d  = w_hs ? i_wdata : wdata_q;
    wstrb_d  = w_hs ? i_wstrb : wstrb_q;
    bresp_d  = bresp_q;
    regs_d   = regs_q;
    base     = int'(cmt_idx) * DATA_WIDTH;
    if (commit) begin
      bresp_d = cmt_err ? RESP_SLVERR : RESP_OKAY;
      if (!cmt_err && !RO_MASK[cmt_idx]) begin
        for (int j = 0; j < STRB_W; j++) begin
          if (cmt_strb[j]) regs_d[base + j*8 +: 8] = cmt_wdata[j*8 +: 8];
        end
      end
    end
  end

  // Read data selection, captured only at the address handshake so the
  // returned word stays frozen while the master stalls rready.
  always_comb begin
    int rbase;
    rbase   = int'(ar_idx) * DATA_WIDTH;
    rd_word = RO_MASK[ar_idx] ? i_ro[rbase +: DATA_WIDTH] : regs_q[rbase +: DATA_WIDTH];
    rdata_d = rdata_q;
    rresp_d = rresp_q;
    if (ar_hs) begin
      rdata_d = ar_err ? '0 : rd_word;
      rresp_d = ar_err ? RESP_SLVERR : RESP_OKAY;
    end
  end

  // Datapath registers; a reset drops any half-collected transaction.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      aw_idx_q <= '0;
      aw_err_q <= 1'b0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
      bresp_q  <= RESP_OKAY;
      regs_q   <= '0;
      rdata_q  <= '0;
      rresp_q  <= RESP_OKAY;
    end else begin
      aw_idx_q <= aw_idx_d;
      aw_err_q <= aw_err_d;
      wdata_q  <= wdata_d;
      wstrb_q  <= wstrb_d;
      bresp_q  <= bresp_d;
      regs_q   <= regs_d;
      rdata_q  <= rdata_d;
      rresp_q  <= rresp_d;
    end
  end

  assign o_bresp = bresp_q;
  assign o_rdata = rdata_q;
  assign o_rresp = rresp_q;
  assign o_regs  = regs_q;

endmodule
